// File: rtl/port1_input.sv
// Input parallel port for the 8051 core: two-flop pin synchroniser, per-bit
// debounce, sticky change flags with level interrupt, and a registered read path.
module port1_input #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins_in,
  input  logic             rd_en,
  input  logic             rd_sel,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             change_irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_nxt;
  logic [WIDTH-1:0] set_flag;
  logic [WIDTH-1:0] flags;
  logic [WIDTH-1:0] flags_nxt;
  logic [WIDTH-1:0] clr;
  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic [7:0]       rd_mux;
  logic [7:0]       data_p0;
  logic             vld_p0;

  // A level differing from deb must survive DEBOUNCE_CYCLES consecutive
  // evaluations; any cycle matching deb restarts the count.
  always_comb begin
    deb_nxt  = deb;
    set_flag = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != deb[i]) begin
        if (cnt[i] == CNT_LAST) begin
          deb_nxt[i]  = sync2[i];
          set_flag[i] = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // Set beats clear so an edge accepted during a flag read is never lost.
  always_comb begin
    clr       = (rd_en && rd_sel) ? flags : '0;
    flags_nxt = (flags & ~clr) | set_flag;
    rd_mux    = '0;
    rd_mux[WIDTH-1:0] = rd_sel ? flags : deb;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1      <= '0;
      sync2      <= '0;
      deb        <= '0;
      flags      <= '0;
      change_irq <= 1'b0;
      vld_p0     <= 1'b0;
      data_p0    <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1      <= pins_in;
      sync2      <= sync1;
      deb        <= deb_nxt;
      flags      <= flags_nxt;
      change_irq <= |flags;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
      // p0: read sample taken on the rd_en edge
      vld_p0 <= rd_en;
      if (rd_en) data_p0 <= rd_mux;
      // p1: presented to the datapath
      rd_valid <= vld_p0;
      if (vld_p0) rd_data <= data_p0;
    end
  end

endmodule

// File: tb/tb_port1_input.sv
// Directed bench for port1_input: synchroniser/debounce timing, glitch and
// bounce rejection, flag read-to-clear with set priority, and async reset.
module tb_port1_input;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] pins_in = 8'h00;
  logic       rd_en = 1'b0;
  logic       rd_sel = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       change_irq;

  int n_chk  = 0;
  int n_pass = 0;

  port1_input #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .pins_in    (pins_in),
    .rd_en      (rd_en),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .change_irq (change_irq)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // rd_en sampled at the first edge; rd_valid/rd_data appear on the next one.
  task automatic do_read(input logic sel, input logic [7:0] exp, input string tag);
    rd_en  = 1'b1;
    rd_sel = sel;
    tick();
    rd_en  = 1'b0;
    rd_sel = 1'b0;
    chk1({tag, "_vld_early"}, rd_valid, 1'b0);
    tick();
    chk1({tag, "_vld"}, rd_valid, 1'b1);
    chk({tag, "_data"}, rd_data, exp);
    tick();
    chk1({tag, "_vld_after"}, rd_valid, 1'b0);
  endtask

  initial begin
    // reset state
    ticks(3);
    chk1("rst_vld", rd_valid, 1'b0);
    chk("rst_data", rd_data, 8'h00);
    chk1("rst_irq", change_irq, 1'b0);
    reset = 1'b1;
    ticks(20);
    chk1("idle_vld", rd_valid, 1'b0);
    chk1("idle_irq", change_irq, 1'b0);
    do_read(1'b0, 8'h00, "idle_pin_rd");

    // stable change 00 -> 05: deb updates on the 6th edge
    pins_in = 8'h05;
    ticks(5);
    chk("deb_e5", dut.deb, 8'h00);
    tick();
    chk("deb_e6", dut.deb, 8'h05);
    chk1("irq_e6", change_irq, 1'b0);
    tick();
    chk1("irq_e7", change_irq, 1'b1);
    do_read(1'b1, 8'h05, "flag_rd1");
    chk1("irq_clr", change_irq, 1'b0);
    do_read(1'b1, 8'h00, "flag_rd2");
    do_read(1'b0, 8'h05, "pin_rd05");

    // 3-cycle glitch on bit 3 is rejected
    pins_in = 8'h0D;
    ticks(3);
    pins_in = 8'h05;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk1("glitch_irq", change_irq, 1'b0);
    end
    chk("glitch_deb", dut.deb, 8'h05);
    do_read(1'b1, 8'h00, "glitch_flags");

    // bounce on bit 7, then held high: accepted 6 edges after the final rise
    pins_in = 8'h85; tick();
    pins_in = 8'h05; tick();
    pins_in = 8'h85; tick();
    pins_in = 8'h05; tick();
    pins_in = 8'h85;
    ticks(5);
    chk("bounce_deb_early", dut.deb, 8'h05);
    tick();
    chk("bounce_deb", dut.deb, 8'h85);
    tick();
    do_read(1'b1, 8'h80, "bounce_flags");
    do_read(1'b1, 8'h00, "bounce_flags2");

    // bit 2 falls -> flags=04; bit 1 accepted on the same edge as the flag read
    pins_in = 8'h81;
    ticks(7);
    chk1("b2_irq", change_irq, 1'b1);
    pins_in = 8'h83;
    ticks(5);
    do_read(1'b1, 8'h04, "coll_rd");
    chk1("coll_irq", change_irq, 1'b1);
    do_read(1'b1, 8'h02, "coll_rd2");
    chk1("coll_irq_clr", change_irq, 1'b0);
    do_read(1'b0, 8'h83, "pin_rd83");

    // pins high through reset produce post-reset flags
    reset   = 1'b0;
    pins_in = 8'hFF;
    ticks(3);
    chk("rst2_deb", dut.deb, 8'h00);
    chk1("rst2_irq", change_irq, 1'b0);
    reset = 1'b1;
    ticks(5);
    chk("ff_deb_e5", dut.deb, 8'h00);
    tick();
    chk("ff_deb_e6", dut.deb, 8'hFF);
    tick();
    chk1("ff_irq", change_irq, 1'b1);

    // reset mid-count and mid-read aborts asynchronously
    pins_in = 8'h00;
    ticks(3);
    rd_en  = 1'b1;
    rd_sel = 1'b1;
    tick();
    rd_en  = 1'b0;
    rd_sel = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk1("async_vld", rd_valid, 1'b0);
    chk1("async_irq", change_irq, 1'b0);
    chk("async_deb", dut.deb, 8'h00);
    chk("async_flags", dut.flags, 8'h00);
    chk("async_data", rd_data, 8'h00);
    ticks(2);
    chk1("async_vld_hold", rd_valid, 1'b0);
    reset = 1'b1;
    ticks(10);
    chk1("post_irq", change_irq, 1'b0);
    do_read(1'b1, 8'h00, "post_flags");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
